ring_fx_sequencer: RTL and testbench

RING_FX_SEQUENCER -- requirements
Module: ring_fx_sequencer

---
 rtl/ring_fx_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_ring_fx_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/ring_fx_sequencer.sv
// Frame-rate effect sequencer for the ring animation: debounced mode button,
// manual/demo mode FSM, demo preset rotation and phase accumulator.
//
//   state     | meaning
//   ----------+--------------------------------------------------------------
//   ST_MANUAL | effect config taken from the synchronised switches, preset 0
//   ST_DEMO   | presets 0..3 cycled every DEMO_FRAMES frames from a fixed table
module ring_fx_sequencer #(
    parameter int DEMO_FRAMES = 120,
    parameter int DEB_FRAMES  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_frame_start,
    input  logic       i_btn_mode,
    input  logic       i_sw_speed,
    input  logic       i_sw_dir,
    output logic [7:0] o_anim_offset,
    output logic       o_speed,
    output logic       o_direction,
    output logic [1:0] o_palette,
    output logic [1:0] o_preset,
    output logic       o_demo_active
);

    typedef enum logic {
        ST_MANUAL = 1'b0,
        ST_DEMO   = 1'b1
    } state_t;

    localparam logic [7:0] DEMO_LAST = 8'(DEMO_FRAMES - 1);
    localparam logic [1:0] DEB_LAST  = 2'(DEB_FRAMES - 1);

    logic       r_btn_meta, r_btn_sync;
    logic       r_spd_meta, r_spd_sync;
    logic       r_dir_meta, r_dir_sync;

    logic       r_db_level;
    logic [1:0] r_db_cnt;

    state_t     r_state;
    logic [7:0] r_demo_cnt;
    logic [6:0] r_phase;
    logic       r_speed;
    logic       r_direction;
    logic [1:0] r_palette;
    logic [1:0] r_preset;
    logic       r_demo_active;

    logic       w_btn_diff;
    logic       w_db_flip;
    logic       w_press;
    state_t     w_state_nxt;
    logic [7:0] w_demo_cnt_nxt;
    logic [1:0] w_preset_nxt;
    logic       w_speed_nxt;
    logic       w_direction_nxt;
    logic [1:0] w_palette_nxt;
    logic       w_demo_active_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btn_meta <= 1'b0;
            r_btn_sync <= 1'b0;
            r_spd_meta <= 1'b0;
            r_spd_sync <= 1'b0;
            r_dir_meta <= 1'b0;
            r_dir_sync <= 1'b0;
        end else begin
            r_btn_meta <= i_btn_mode;
            r_btn_sync <= r_btn_meta;
            r_spd_meta <= i_sw_speed;
            r_spd_sync <= r_spd_meta;
            r_dir_meta <= i_sw_dir;
            r_dir_sync <= r_dir_meta;
        end
    end

    assign w_btn_diff = (r_btn_sync != r_db_level);
    assign w_db_flip  = w_btn_diff && (r_db_cnt == DEB_LAST);
    // A press is the frame on which the debounced level rises.
    assign w_press    = i_frame_start && w_db_flip && r_btn_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_db_level <= 1'b0;
            r_db_cnt   <= 2'd0;
        end else if (i_frame_start) begin
            if (w_db_flip) begin
                r_db_level <= r_btn_sync;
                r_db_cnt   <= 2'd0;
            end else if (w_btn_diff) begin
                r_db_cnt <= r_db_cnt + 2'd1;
            end else begin
                r_db_cnt <= 2'd0;
            end
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_demo_cnt_nxt    = r_demo_cnt;
        w_preset_nxt      = r_preset;
        w_speed_nxt       = 1'b0;
        w_direction_nxt   = 1'b0;
        w_palette_nxt     = 2'd0;
        w_demo_active_nxt = 1'b0;

        case (r_state)
            ST_MANUAL: begin
                w_demo_cnt_nxt = 8'd0;
                w_preset_nxt   = 2'd0;
                if (w_press) begin
                    w_state_nxt = ST_DEMO;
                end
            end
            ST_DEMO: begin
                if (w_press) begin
                    w_state_nxt    = ST_MANUAL;
                    w_demo_cnt_nxt = 8'd0;
                    w_preset_nxt   = 2'd0;
                end else if (r_demo_cnt == DEMO_LAST) begin
                    w_demo_cnt_nxt = 8'd0;
                    w_preset_nxt   = r_preset + 2'd1;
                end else begin
                    w_demo_cnt_nxt = r_demo_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt    = ST_MANUAL;
                w_demo_cnt_nxt = 8'd0;
                w_preset_nxt   = 2'd0;
            end
        endcase

        // Outputs follow the post-edge mode so a mode switch shows on its own frame.
        if (w_state_nxt == ST_DEMO) begin
            w_demo_active_nxt = 1'b1;
            case (w_preset_nxt)
                2'd0: begin w_speed_nxt = 1'b0; w_direction_nxt = 1'b0; w_palette_nxt = 2'd0; end
                2'd1: begin w_speed_nxt = 1'b1; w_direction_nxt = 1'b0; w_palette_nxt = 2'd1; end
                2'd2: begin w_speed_nxt = 1'b0; w_direction_nxt = 1'b1; w_palette_nxt = 2'd2; end
                default: begin w_speed_nxt = 1'b1; w_direction_nxt = 1'b1; w_palette_nxt = 2'd3; end
            endcase
        end else begin
            w_preset_nxt    = 2'd0;
            w_speed_nxt     = r_spd_sync;
            w_direction_nxt = r_dir_sync;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_MANUAL;
            r_demo_cnt    <= 8'd0;
            r_phase       <= 7'd0;
            r_speed       <= 1'b0;
            r_direction   <= 1'b0;
            r_palette     <= 2'd0;
            r_preset      <= 2'd0;
            r_demo_active <= 1'b0;
        end else if (i_frame_start) begin
            r_state       <= w_state_nxt;
            r_demo_cnt    <= w_demo_cnt_nxt;
            r_phase       <= r_phase + (r_speed ? 7'd2 : 7'd1);
            r_speed       <= w_speed_nxt;
            r_direction   <= w_direction_nxt;
            r_palette     <= w_palette_nxt;
            r_preset      <= w_preset_nxt;
            r_demo_active <= w_demo_active_nxt;
        end
    end

    assign o_anim_offset = {r_phase, 1'b0};
    assign o_speed       = r_speed;
    assign o_direction   = r_direction;
    assign o_palette     = r_palette;
    assign o_preset      = r_preset;
    assign o_demo_active = r_demo_active;

endmodule

// File: tb/tb_ring_fx_sequencer.sv
// Directed bench for ring_fx_sequencer with a short demo period (4 frames).
module tb_ring_fx_sequencer;

    logic       clk;
    logic       rst_n;
    logic       i_frame_start;
    logic       i_btn_mode;
    logic       i_sw_speed;
    logic       i_sw_dir;
    logic [7:0] o_anim_offset;
    logic       o_speed;
    logic       o_direction;
    logic [1:0] o_palette;
    logic [1:0] o_preset;
    logic       o_demo_active;

    int n_assert = 0;
    int n_fail   = 0;
    int ph       = 0;
    bit spd      = 1'b0;
    int hold_off;

    ring_fx_sequencer #(.DEMO_FRAMES(4), .DEB_FRAMES(3)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_frame_start (i_frame_start),
        .i_btn_mode    (i_btn_mode),
        .i_sw_speed    (i_sw_speed),
        .i_sw_dir      (i_sw_dir),
        .o_anim_offset (o_anim_offset),
        .o_speed       (o_speed),
        .o_direction   (o_direction),
        .o_palette     (o_palette),
        .o_preset      (o_preset),
        .o_demo_active (o_demo_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One frame: idle cycles let switch/button changes clear the synchronisers,
    // then a single-cycle frame_start. Returns on the following negedge.
    // nspd is the speed expected after this edge; phase steps by the old one.
    task automatic fs(input bit nspd);
        repeat (4) @(negedge clk);
        i_frame_start = 1'b1;
        @(negedge clk);
        i_frame_start = 1'b0;
        ph  = (ph + (spd ? 2 : 1)) % 128;
        spd = nspd;
    endtask

    task automatic chk_cfg(input string tag, input int s, input int d, input int p, input int pre, input int dm);
        chk({tag, "_speed"},  int'(o_speed), s);
        chk({tag, "_dir"},    int'(o_direction), d);
        chk({tag, "_pal"},    int'(o_palette), p);
        chk({tag, "_preset"}, int'(o_preset), pre);
        chk({tag, "_demo"},   int'(o_demo_active), dm);
    endtask

    initial begin
        rst_n = 1'b0;
        i_frame_start = 1'b0;
        i_btn_mode = 1'b0;
        i_sw_speed = 1'b0;
        i_sw_dir = 1'b0;
        #1;
        chk("rst_offset", int'(o_anim_offset), 0);
        chk_cfg("rst", 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int k = 1; k <= 5; k++) begin
            fs(1'b0);
            chk("idle_offset", int'(o_anim_offset), 2 * k);
        end
        chk_cfg("idle", 0, 0, 0, 0, 0);

        i_sw_speed = 1'b1;
        fs(1'b1);
        chk("fast_first_speed", int'(o_speed), 1);
        chk("fast_first_offset", int'(o_anim_offset), 12);
        fs(1'b1);
        chk("fast_second_offset", int'(o_anim_offset), 16);
        fs(1'b1);
        i_sw_speed = 1'b0;
        fs(1'b0);
        chk("slow_again_offset", int'(o_anim_offset), 24);
        i_sw_speed = 1'b1;
        fs(1'b1);
        chk("odd_phase_offset", int'(o_anim_offset), 26);
        for (int k = 0; k < 57; k++) fs(1'b1);
        chk("phase127_offset", int'(o_anim_offset), 254);
        fs(1'b1);
        chk("wrap_offset", int'(o_anim_offset), 2);
        i_sw_dir = 1'b1;
        fs(1'b1);
        chk("manual_dir", int'(o_direction), 1);
        hold_off = 2 * ph;
        repeat (6) @(negedge clk);
        chk("hold_between_fs", int'(o_anim_offset), hold_off);

        i_sw_speed = 1'b0;
        i_sw_dir = 1'b0;
        fs(1'b0);
        chk_cfg("manual_zero", 0, 0, 0, 0, 0);
        i_btn_mode = 1'b1;
        fs(1'b0);
        fs(1'b0);
        i_btn_mode = 1'b0;
        fs(1'b0);
        chk("short_press_demo", int'(o_demo_active), 0);
        i_btn_mode = 1'b1;
        fs(1'b0);
        fs(1'b0);
        chk("press_2nd_demo", int'(o_demo_active), 0);
        fs(1'b0);
        chk_cfg("demo_entry", 0, 0, 0, 0, 1);
        chk("demo_entry_offset", int'(o_anim_offset), 2 * ph);

        fs(1'b0); fs(1'b0); fs(1'b0);
        chk("preset0_held", int'(o_preset), 0);
        fs(1'b1);
        chk_cfg("preset1", 1, 0, 1, 1, 1);
        hold_off = 2 * ph;
        fs(1'b1);
        chk("preset1_step2", int'(o_anim_offset), (hold_off + 4) % 256);
        fs(1'b1); fs(1'b1);
        fs(1'b0);
        chk_cfg("preset2", 0, 1, 2, 2, 1);
        fs(1'b0); fs(1'b0); fs(1'b0);
        fs(1'b1);
        chk_cfg("preset3", 1, 1, 3, 3, 1);
        fs(1'b1); fs(1'b1); fs(1'b1);
        fs(1'b0);
        chk_cfg("preset_wrap", 0, 0, 0, 0, 1);
        chk("preset_wrap_offset", int'(o_anim_offset), 2 * ph);

        i_sw_speed = 1'b1;
        i_sw_dir = 1'b1;
        i_btn_mode = 1'b0;
        fs(1'b0); fs(1'b0); fs(1'b0);
        chk_cfg("release_in_demo", 0, 0, 0, 0, 1);
        i_btn_mode = 1'b1;
        fs(1'b1); fs(1'b1);
        chk("demo_before_exit", int'(o_demo_active), 1);
        fs(1'b1);
        chk_cfg("exit_manual", 1, 1, 0, 0, 0);
        chk("exit_offset", int'(o_anim_offset), 2 * ph);

        i_btn_mode = 1'b0;
        fs(1'b1); fs(1'b1); fs(1'b1);
        i_btn_mode = 1'b1;
        fs(1'b1); fs(1'b1);
        fs(1'b0);
        chk("reenter_demo", int'(o_demo_active), 1);
        fs(1'b0); fs(1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset_offset", int'(o_anim_offset), 0);
        chk_cfg("midreset", 0, 0, 0, 0, 0);
        i_btn_mode = 1'b0;
        i_sw_speed = 1'b0;
        i_sw_dir = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        ph = 0;
        spd = 1'b0;
        fs(1'b0);
        chk("post_reset_offset", int'(o_anim_offset), 2);
        chk_cfg("post_reset", 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
